// File: rtl/mem_wait_responder_if.sv
// Bus between the SLC-3 control FSM / datapath (master) and the wait-state memory responder (slave).
interface mem_wait_responder_if #(
  parameter int DATA_W = 16
);
  logic              Mem_OE;
  logic              Mem_WE;
  logic [15:0]       MAR;
  logic [DATA_W-1:0] MDR_In;
  logic [DATA_W-1:0] Data_to_CPU;
  logic              Mem_Rdy;
  logic              Busy;
  logic              Conflict;

  modport master (
    output Mem_OE, Mem_WE, MAR, MDR_In,
    input  Data_to_CPU, Mem_Rdy, Busy, Conflict
  );

  modport slave (
    input  Mem_OE, Mem_WE, MAR, MDR_In,
    output Data_to_CPU, Mem_Rdy, Busy, Conflict
  );
endinterface

// File: rtl/mem_wait_responder.sv
// Memory-side responder for the SLC-3: on-chip word array, fixed wait states, one-cycle Mem_Rdy pulse.
// Optional MEM_IO_SWITCH_EN maps MAR==16'hFFFF to Switches (read) and Hex_Out (write).
module mem_wait_responder #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 2   // legal range 1..15
) (
  input  logic        Clk,
  input  logic        Reset,
`ifdef MEM_IO_SWITCH_EN
  input  logic [15:0] Switches,
  output logic [15:0] Hex_Out,
`endif
  mem_wait_responder_if.slave bus
);

  localparam int CNT_W = 4;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_STATES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    WR_WAIT = 3'd2,
    DONE    = 3'd3,
    HOLD    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              rdy_q, rdy_d;
  logic              busy_q, busy_d;
  logic              conflict_q, conflict_d;
  logic              arr_we_s;
  logic [DATA_W-1:0] rd_data_s;
  logic [DATA_W-1:0] mem_array [DEPTH];
  logic              unused_mar_s;
`ifdef MEM_IO_SWITCH_EN
  logic              io_sel_q, io_sel_d;
  logic [15:0]       hex_q, hex_d;
`endif

  // Upper MAR bits alias onto the array and are deliberately dropped.
  assign unused_mar_s = ^bus.MAR[15:ADDR_W];

  // Read source at completion: switches for the mapped I/O address, otherwise the array
  always_comb begin
`ifdef MEM_IO_SWITCH_EN
    if (io_sel_q) begin
      rd_data_s = DATA_W'(Switches);
    end else begin
      rd_data_s = mem_array[addr_q];
    end
`else
    rd_data_s = mem_array[addr_q];
`endif
  end

  // Next-state, capture and completion logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    data_d     = data_q;
    conflict_d = conflict_q;
    arr_we_s   = 1'b0;
`ifdef MEM_IO_SWITCH_EN
    io_sel_d   = io_sel_q;
    hex_d      = hex_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef MEM_IO_SWITCH_EN
        io_sel_d = (bus.MAR == 16'hFFFF);
`endif
        // A write wins over a simultaneous read; the overlap is recorded sticky.
        if (bus.Mem_WE) begin
          state_d = WR_WAIT;
          cnt_d   = CNT_INIT;
          addr_d  = bus.MAR[ADDR_W-1:0];
          wdata_d = bus.MDR_In;
          if (bus.Mem_OE) begin
            conflict_d = 1'b1;
          end else begin
            conflict_d = conflict_q;
          end
        end else if (bus.Mem_OE) begin
          state_d = RD_WAIT;
          cnt_d   = CNT_INIT;
          addr_d  = bus.MAR[ADDR_W-1:0];
        end else begin
          state_d = IDLE;
        end
      end
      RD_WAIT: begin
        if (!bus.Mem_OE) begin
          state_d = IDLE;
        end else if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = DONE;
          data_d  = rd_data_s;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WR_WAIT: begin
        if (!bus.Mem_WE) begin
          state_d = IDLE;
        end else if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = DONE;
`ifdef MEM_IO_SWITCH_EN
          if (io_sel_q) begin
            hex_d = 16'(wdata_q);
          end else begin
            arr_we_s = 1'b1;
          end
`else
          arr_we_s = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (bus.Mem_OE || bus.Mem_WE) begin
          state_d = HOLD;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        // Strobes must fall before another access; one pulse per assertion.
        if (!bus.Mem_OE && !bus.Mem_WE) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    rdy_d  = (state_d == DONE);
  end

  // Control and output registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      addr_q     <= {ADDR_W{1'b0}};
      wdata_q    <= {DATA_W{1'b0}};
      data_q     <= {DATA_W{1'b0}};
      rdy_q      <= 1'b0;
      busy_q     <= 1'b0;
      conflict_q <= 1'b0;
`ifdef MEM_IO_SWITCH_EN
      io_sel_q   <= 1'b0;
      hex_q      <= 16'h0000;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      data_q     <= data_d;
      rdy_q      <= rdy_d;
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
`ifdef MEM_IO_SWITCH_EN
      io_sel_q   <= io_sel_d;
      hex_q      <= hex_d;
`endif
    end
  end

  // Word array; contents survive reset
  always_ff @(posedge Clk) begin
    if (arr_we_s) begin
      mem_array[addr_q] <= wdata_q;
    end
  end

  assign bus.Data_to_CPU = data_q;
  assign bus.Mem_Rdy     = rdy_q;
  assign bus.Busy        = busy_q;
  assign bus.Conflict    = conflict_q;
`ifdef MEM_IO_SWITCH_EN
  assign Hex_Out         = hex_q;
`endif

endmodule
